h_bridge_deadtime: RTL and testbench

- Sits directly downstream of a PWM channel's H-bridge decoder, between its H_bridge_1/H_bridge_2 outputs and the FPGA pins driving the external H-bridge driver.
- Enforces a programmable dead time (both outputs low) between any two different drive patterns.
- Latches external driver faults (nFault pin) and forces the bridge off until software clears the fault.
- All timing is in 20 nS clock cycles.

---
 rtl/h_bridge_deadtime.sv | 159 +++++++++++++++
 tb/tb_h_bridge_deadtime.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h_bridge_deadtime.sv
// h_bridge_deadtime: dead-time and fault guard between a PWM H-bridge decoder and the bridge driver pins.
//
// Every change between two different drive patterns passes through a dead-time gap with both
// outputs low. A falling external fault is synchronised, latched, and holds the bridge off
// until software clears it. All timing is in clk cycles (20 ns at 50 MHz).
//
// Optional feature: define HB_MIN_ON_EN to enforce a minimum DRIVE dwell of MIN_ON cycles.
//
// Ports:
//   i_clk            system clock, 50 MHz
//   i_reset          synchronous, active-low reset
//   i_enable         bridge enable from the PWM config register
//   i_dead_time      dead time D in cycles; outputs are low for D+1 cycles between patterns
//   i_in_1, i_in_2   requested bridge signals from the PWM channel
//   i_ext_fault_n    asynchronous active-low fault from the external driver
//   i_fault_clear    single-cycle pulse that clears a latched fault
//   o_out_1, o_out_2 registered bridge pins
//   o_fault_latched  1 while in FAULT
//   o_state_out      current state: OFF=0, DRIVE=1, DEAD=2, FAULT=3
module h_bridge_deadtime #(
    parameter int DT_WIDTH     = 8,
    parameter int MIN_ON       = 4,
    parameter int MIN_ON_WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [DT_WIDTH-1:0] i_dead_time,
    input  logic                i_in_1,
    input  logic                i_in_2,
    input  logic                i_ext_fault_n,
    input  logic                i_fault_clear,
    output logic                o_out_1,
    output logic                o_out_2,
    output logic                o_fault_latched,
    output logic [1:0]          o_state_out
);
    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DEAD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          r_pat;
    logic [DT_WIDTH-1:0] r_cnt;
    logic                r_sync1;
    logic                r_sync2;
    logic [1:0]          r_out;
    logic                r_fault;

    logic [1:0]          w_req;
    logic                w_flt_n;
    logic [1:0]          w_state;
    logic [1:0]          w_pat;
    logic [DT_WIDTH-1:0] w_cnt;

    assign w_req   = {i_in_1, i_in_2};
    assign w_flt_n = r_sync2;

`ifdef HB_MIN_ON_EN
    localparam logic [MIN_ON_WIDTH-1:0] MIN_ON_LAST = MIN_ON_WIDTH'(MIN_ON - 1);
    logic [MIN_ON_WIDTH-1:0] r_mcnt;
    logic [MIN_ON_WIDTH-1:0] w_mcnt;
`else
    logic w_unused_min_on;
    assign w_unused_min_on = ^{MIN_ON, MIN_ON_WIDTH};
`endif

    always_comb begin
        w_state = r_state;
        w_pat   = r_pat;
        w_cnt   = r_cnt;
`ifdef HB_MIN_ON_EN
        w_mcnt  = r_mcnt;
`endif
        case (r_state)
            S_OFF: begin
                if (!w_flt_n) begin
                    w_state = S_FAULT;
                end else if (i_enable && w_req != 2'b00) begin
                    w_state = S_DRIVE;
                    w_pat   = w_req;
                end
            end
            S_DRIVE: begin
                if (!w_flt_n) begin
                    w_state = S_FAULT;
`ifdef HB_MIN_ON_EN
                // Pending req/enable changes wait until the dwell has expired.
                end else if (r_mcnt != '0) begin
                    w_mcnt = r_mcnt - MIN_ON_WIDTH'(1);
`endif
                end else if (!i_enable || w_req != r_pat) begin
                    w_state = S_DEAD;
                    w_cnt   = i_dead_time;
                end
            end
            S_DEAD: begin
                if (!w_flt_n) begin
                    w_state = S_FAULT;
                end else if (r_cnt != '0) begin
                    w_cnt = r_cnt - DT_WIDTH'(1);
                end else if (!i_enable || w_req == 2'b00) begin
                    w_state = S_OFF;
                end else begin
                    w_state = S_DRIVE;
                    w_pat   = w_req;
                end
            end
            default: begin
                // Leaving FAULT always goes through a full gap.
                if (i_fault_clear && w_flt_n) begin
                    w_state = S_DEAD;
                    w_cnt   = i_dead_time;
                end
            end
        endcase
`ifdef HB_MIN_ON_EN
        if (w_state == S_DRIVE && r_state != S_DRIVE) w_mcnt = MIN_ON_LAST;
`endif
    end

    // Outputs are computed from the next state so a request sampled on an edge
    // is visible right after that same edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_OFF;
            r_pat   <= 2'b00;
            r_cnt   <= '0;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_out   <= 2'b00;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pat   <= w_pat;
            r_cnt   <= w_cnt;
            r_sync1 <= i_ext_fault_n;
            r_sync2 <= r_sync1;
            r_out   <= (w_state == S_DRIVE) ? w_pat : 2'b00;
            r_fault <= (w_state == S_FAULT);
        end
    end

`ifdef HB_MIN_ON_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_mcnt <= '0;
        end else begin
            r_mcnt <= w_mcnt;
        end
    end
`endif

    assign o_out_1         = r_out[1];
    assign o_out_2         = r_out[0];
    assign o_fault_latched = r_fault;
    assign o_state_out     = r_state;
endmodule

// File: tb/tb_h_bridge_deadtime.sv
// tb_h_bridge_deadtime: directed scenarios plus random stimulus against a behavioural model.
module tb_h_bridge_deadtime;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] dead_time;
    logic       in_1;
    logic       in_2;
    logic       ext_fault_n;
    logic       fault_clear;
    logic       out_1;
    logic       out_2;
    logic       fault_latched;
    logic [1:0] state_out;

`ifdef HB_MIN_ON_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 1;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Model: flags for faulted / driving / in a gap, a remaining-gap count, and the fault pin history.
    bit         s1 = 1'b1;
    bit         s2 = 1'b1;
    bit         faulted;
    bit         driving;
    bit         in_gap;
    int         gap;
    int         hold_left;
    logic [1:0] pat;
    logic [1:0] exp_out;
    logic [1:0] exp_state;
    logic       exp_fl;

    h_bridge_deadtime dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_dead_time    (dead_time),
        .i_in_1         (in_1),
        .i_in_2         (in_2),
        .i_ext_fault_n  (ext_fault_n),
        .i_fault_clear  (fault_clear),
        .o_out_1        (out_1),
        .o_out_2        (out_2),
        .o_fault_latched(fault_latched),
        .o_state_out    (state_out)
    );

    always #10 clk = ~clk;

    task automatic start_drive(input logic [1:0] r);
        driving   = 1'b1;
        pat       = r;
        hold_left = HOLD - 1;
    endtask

    task automatic step();
        bit         flt;
        logic [1:0] req;
        req = {in_1, in_2};
        @(posedge clk);
        if (!reset) begin
            s1 = 1'b1; s2 = 1'b1; faulted = 1'b0; driving = 1'b0; in_gap = 1'b0;
            gap = 0; hold_left = 0; pat = 2'b00;
        end else begin
            flt = s2;
            s2  = s1;
            s1  = ext_fault_n;
            if (faulted) begin
                if (fault_clear && flt) begin
                    faulted = 1'b0; in_gap = 1'b1; gap = int'(dead_time);
                end
            end else if (!flt) begin
                faulted = 1'b1; driving = 1'b0; in_gap = 1'b0;
            end else if (driving) begin
                if (hold_left > 0) hold_left--;
                else if (!enable || req != pat) begin
                    driving = 1'b0; in_gap = 1'b1; gap = int'(dead_time);
                end
            end else if (in_gap) begin
                if (gap > 0) gap--;
                else begin
                    in_gap = 1'b0;
                    if (enable && req != 2'b00) start_drive(req);
                end
            end else if (enable && req != 2'b00) begin
                start_drive(req);
            end
        end
        exp_out   = driving ? pat : 2'b00;
        exp_state = faulted ? 2'd3 : driving ? 2'd1 : in_gap ? 2'd2 : 2'd0;
        exp_fl    = faulted;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; {in_1, in_2} = 2'b11; ext_fault_n = 1'b1;
        fault_clear = 1'b0; dead_time = 8'd0;
        repeat (2) step();
        vectors++;
        if ({out_1, out_2, state_out, fault_latched} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset: out=%b%b st=%0d fl=%b, need out=00 st=0 fl=0", out_1, out_2, state_out, fault_latched);
        end
        reset = 1'b1; enable = 1'b1; {in_1, in_2} = 2'b10;
        step();
        vectors++;
        if ({out_1, out_2, state_out} !== 4'b1001) begin
            miscompares++;
            $display("FAIL reset_first_drive: out=%b%b st=%0d, need out=10 st=1", out_1, out_2, state_out);
        end
    endtask

    task automatic test_dead_time();
        int n = 0;
        dead_time = 8'd5; {in_1, in_2} = 2'b10;
        repeat (6) step();
        {in_1, in_2} = 2'b01;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if ({out_1, out_2, state_out, fault_latched} !== {exp_out, exp_state, exp_fl}) begin
                miscompares++;
                $display("FAIL dead_time_model: out=%b%b st=%0d fl=%b, need out=%b st=%0d fl=%b", out_1, out_2, state_out, fault_latched, exp_out, exp_state, exp_fl);
            end
            if ({out_1, out_2} == 2'b00) n++;
            else break;
        end
        vectors++;
        if (n != 6 || {out_1, out_2} !== 2'b01) begin
            miscompares++;
            $display("FAIL dead_time_gap: gap=%0d out=%b%b, need gap=6 out=01", n, out_1, out_2);
        end
    endtask

    task automatic test_off_path();
        dead_time = 8'd0; {in_1, in_2} = 2'b01;
        repeat (6) step();
        {in_1, in_2} = 2'b00;
        step();
        vectors++;
        if ({out_1, out_2, state_out} !== 4'b0010) begin
            miscompares++;
            $display("FAIL zero_dt_dead: out=%b%b st=%0d, need out=00 st=2", out_1, out_2, state_out);
        end
        step();
        vectors++;
        if ({out_1, out_2, state_out} !== 4'b0000) begin
            miscompares++;
            $display("FAIL zero_dt_off: out=%b%b st=%0d, need out=00 st=0", out_1, out_2, state_out);
        end
        {in_1, in_2} = 2'b11;
        step();
        vectors++;
        if ({out_1, out_2, state_out} !== 4'b1101 || {out_1, out_2, state_out} !== {exp_out, exp_state}) begin
            miscompares++;
            $display("FAIL off_to_drive: out=%b%b st=%0d, need out=11 st=1", out_1, out_2, state_out);
        end
    endtask

    task automatic test_fault();
        int n = 1;
        dead_time = 8'd3; {in_1, in_2} = 2'b10;
        repeat (12) step();
        for (int i = 0; i < 3; i++) begin
            ext_fault_n = (i != 0);
            step();
            vectors++;
            if ({out_1, out_2, state_out, fault_latched} !== ((i < 2) ? 5'b10010 : 5'b00111) ||
                {out_1, out_2, state_out, fault_latched} !== {exp_out, exp_state, exp_fl}) begin
                miscompares++;
                $display("FAIL fault_entry edge %0d: out=%b%b st=%0d fl=%b, need out=%b st=%0d fl=%b", i + 1, out_1, out_2, state_out, fault_latched, exp_out, exp_state, exp_fl);
            end
        end
        ext_fault_n = 1'b0;
        repeat (2) step();
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        vectors++;
        if ({state_out, fault_latched} !== 3'b111) begin
            miscompares++;
            $display("FAIL fault_clear_ignored: st=%0d fl=%b, need st=3 fl=1", state_out, fault_latched);
        end
        ext_fault_n = 1'b1;
        repeat (2) step();
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        vectors++;
        if ({out_1, out_2, state_out, fault_latched} !== 5'b00100) begin
            miscompares++;
            $display("FAIL fault_release: out=%b%b st=%0d fl=%b, need out=00 st=2 fl=0", out_1, out_2, state_out, fault_latched);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (state_out == 2'd2) n++;
            else break;
        end
        vectors++;
        if (n != 4 || {out_1, out_2, state_out} !== 4'b1001) begin
            miscompares++;
            $display("FAIL fault_gap: gap=%0d out=%b%b st=%0d, need gap=4 out=10 st=1", n, out_1, out_2, state_out);
        end
    endtask

    task automatic test_enable_drop();
        int n = 1;
        dead_time = 8'd3; {in_1, in_2} = 2'b10; enable = 1'b1;
        repeat (6) step();
        enable = 1'b0;
        step();
        dead_time = 8'd9;
        for (int i = 0; i < 20; i++) begin
            {in_1, in_2} = 2'($urandom);
            step();
            if (state_out == 2'd2) n++;
            else break;
        end
        vectors++;
        if (n != 4 || {out_1, out_2, state_out} !== 4'b0000) begin
            miscompares++;
            $display("FAIL enable_drop_gap: gap=%0d out=%b%b st=%0d, need gap=4 out=00 st=0", n, out_1, out_2, state_out);
        end
        for (int i = 0; i < 4; i++) begin
            {in_1, in_2} = 2'(i + 1);
            step();
            vectors++;
            if ({out_1, out_2, state_out} !== 4'b0000 || {out_1, out_2, state_out, fault_latched} !== {exp_out, exp_state, exp_fl}) begin
                miscompares++;
                $display("FAIL disabled_off: out=%b%b st=%0d, need out=00 st=0", out_1, out_2, state_out);
            end
        end
    endtask

    task automatic test_min_on();
        int n = 1;
        dead_time = 8'd2; enable = 1'b1; {in_1, in_2} = 2'b10;
        step();
        {in_1, in_2} = 2'b01;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({out_1, out_2} == 2'b10) n++;
            else break;
        end
        vectors++;
        if (n != HOLD || {out_1, out_2, state_out} !== 4'b0010) begin
            miscompares++;
            $display("FAIL min_on: on=%0d out=%b%b st=%0d, need on=%0d out=00 st=2", n, out_1, out_2, state_out, HOLD);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 99) != 0);
            enable      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) {in_1, in_2} = 2'($urandom);
            ext_fault_n = ($urandom_range(0, 59) != 0);
            fault_clear = ($urandom_range(0, 7) == 0);
            dead_time   = 8'($urandom_range(0, 6));
            step();
            vectors++;
            if ({out_1, out_2, state_out, fault_latched} !== {exp_out, exp_state, exp_fl}) begin
                miscompares++;
                $display("FAIL random cycle %0d: out=%b%b st=%0d fl=%b, need out=%b st=%0d fl=%b", i, out_1, out_2, state_out, fault_latched, exp_out, exp_state, exp_fl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dead_time();
        test_off_path();
        test_fault();
        test_enable_drop();
        test_min_on();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
